// File: rtl/nibble_frame_store.sv
// Single-clock pixel frame store: edge-triggered write/read strobes, rewindable pointers, registered RAM read.
// Optional FRAME_STORE_DOUBLE_BUFFER_EN adds a second bank so the reader replays the last completed frame.
module nibble_frame_store #(
  parameter int WIDTH      = 4,
  parameter int DEPTH      = 76800,
  parameter int ADDR_WIDTH = 17
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in,
  input  logic             write,
  input  logic             read,
  input  logic             reset_write_ptr,
  input  logic             reset_read_ptr,
  output logic [WIDTH-1:0] out,
  output logic             frame_written,
  output logic             overflow
);

`ifdef FRAME_STORE_DOUBLE_BUFFER_EN
  localparam int MEM_WORDS = 2 * DEPTH;
  localparam int MEM_AW    = ADDR_WIDTH + 1;
`else
  localparam int MEM_WORDS = DEPTH;
  localparam int MEM_AW    = ADDR_WIDTH;
`endif

  localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(DEPTH - 1);

  logic [WIDTH-1:0]      mem [MEM_WORDS];
  logic [MEM_AW-1:0]     wr_addr, rd_addr;

  logic                  write_q, read_q, in_reset_q;
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic                  wrapped_q, wrapped_d;
  logic                  frame_written_q, frame_written_d;
  logic                  overflow_q, overflow_d;
  logic                  wr_evt, rd_evt, wr_en, rd_en;

  // A strobe held high across reset deassertion is masked for one cycle, by
  // which time write_q/read_q have caught up and no false edge is seen.
  assign wr_evt = write & ~write_q & ~in_reset_q;
  assign rd_evt = read  & ~read_q  & ~in_reset_q;
  assign wr_en  = wr_evt & ~reset_write_ptr & ~reset;
  assign rd_en  = rd_evt & ~reset_read_ptr  & ~reset;

  // NOTE: every next-state signal gets its hold value first so no path leaves it unassigned (no latch).
  always_comb begin
    wr_ptr_d        = wr_ptr_q;
    rd_ptr_d        = rd_ptr_q;
    wrapped_d       = wrapped_q;
    overflow_d      = overflow_q;
    frame_written_d = 1'b0;
    if (reset_write_ptr) begin
      wr_ptr_d  = '0;
      wrapped_d = 1'b0;
    end else if (wr_en) begin
      wr_ptr_d = (wr_ptr_q == LAST) ? '0 : wr_ptr_q + ADDR_WIDTH'(1);
      if (wrapped_q) overflow_d = 1'b1;
      if (wr_ptr_q == LAST) begin
        wrapped_d       = 1'b1;
        frame_written_d = 1'b1;
      end
    end
    if (reset_read_ptr) begin
      rd_ptr_d = '0;
    end else if (rd_en) begin
      rd_ptr_d = (rd_ptr_q == LAST) ? '0 : rd_ptr_q + ADDR_WIDTH'(1);
    end
  end

  // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      write_q         <= 1'b0;
      read_q          <= 1'b0;
      in_reset_q      <= 1'b1;
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
      wrapped_q       <= 1'b0;
      frame_written_q <= 1'b0;
      overflow_q      <= 1'b0;
    end else begin
      write_q         <= write;
      read_q          <= read;
      in_reset_q      <= 1'b0;
      wr_ptr_q        <= wr_ptr_d;
      rd_ptr_q        <= rd_ptr_d;
      wrapped_q       <= wrapped_d;
      frame_written_q <= frame_written_d;
      overflow_q      <= overflow_d;
    end
  end

`ifdef FRAME_STORE_DOUBLE_BUFFER_EN
  logic wr_bank_q, rd_bank_q, rst_wr_q, rst_rd_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b1;
      rst_wr_q  <= 1'b0;
      rst_rd_q  <= 1'b0;
    end else begin
      rst_wr_q <= reset_write_ptr;
      rst_rd_q <= reset_read_ptr;
      if (reset_write_ptr && !rst_wr_q) wr_bank_q <= ~wr_bank_q;
      if (reset_read_ptr && !rst_rd_q)  rd_bank_q <= ~wr_bank_q;
    end
  end

  // Bank 1 sits directly above bank 0, so the RAM is exactly 2*DEPTH words.
  assign wr_addr = wr_bank_q ? MEM_AW'(wr_ptr_q) + MEM_AW'(DEPTH) : MEM_AW'(wr_ptr_q);
  assign rd_addr = rd_bank_q ? MEM_AW'(rd_ptr_q) + MEM_AW'(DEPTH) : MEM_AW'(rd_ptr_q);
`else
  assign wr_addr = wr_ptr_q;
  assign rd_addr = rd_ptr_q;
`endif

  // NOTE: the RAM array has no reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= in;
  end

  // Read-first: a same-address write this edge shows up one cycle later.
  always_ff @(posedge clk) begin
    if (reset) out <= '0;
    else       out <= mem[rd_addr];
  end

  assign frame_written = frame_written_q;
  assign overflow      = overflow_q;

endmodule

// File: tb/tb_nibble_frame_store.sv
// Randomised bench for nibble_frame_store (DEPTH=8 build) against a transaction-level model.
module tb_nibble_frame_store;

  localparam int WIDTH = 4;
  localparam int DEPTH = 8;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [WIDTH-1:0] in = '0;
  logic             write = 1'b0;
  logic             read = 1'b0;
  logic             reset_write_ptr = 1'b0;
  logic             reset_read_ptr = 1'b0;
  logic [WIDTH-1:0] out;
  logic             frame_written;
  logic             overflow;

  nibble_frame_store #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_WIDTH(3)) dut (
    .clk             (clk),
    .reset           (reset),
    .in              (in),
    .write           (write),
    .read            (read),
    .reset_write_ptr (reset_write_ptr),
    .reset_read_ptr  (reset_read_ptr),
    .out             (out),
    .frame_written   (frame_written),
    .overflow        (overflow)
  );

  always #5 clk = ~clk;

  // Reference model: frame contents plus pointers and flags, updated per strobe transaction.
  logic [WIDTH-1:0] mem_m [DEPTH];
  bit               known_m [DEPTH];
  int               wp, rp;
  bit               wrapped_m, ovf_m;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    check("rst_out", out, 0);
    check("rst_fw", frame_written, 0);
    check("rst_ovf", overflow, 0);
    tick();
    reset = 1'b0;
    wp = 0;
    rp = 0;
    wrapped_m = 1'b0;
    ovf_m = 1'b0;
    tick();
  endtask

  // One strobe transaction: inputs high for one cycle, then two idle cycles.
  task automatic op(input bit w, input bit r, input bit rwp, input bit rrp, input logic [WIDTH-1:0] d);
    logic [WIDTH-1:0] old_word;
    bit               old_known;
    bit               exp_fw;
    old_known = known_m[rp];
    old_word  = mem_m[rp];
    exp_fw    = w && !rwp && (wp == DEPTH - 1);
    if (rwp) begin
      wp = 0;
      wrapped_m = 1'b0;
    end else if (w) begin
      if (wrapped_m) ovf_m = 1'b1;
      mem_m[wp] = d;
      known_m[wp] = 1'b1;
      if (wp == DEPTH - 1) wrapped_m = 1'b1;
      wp = (wp + 1) % DEPTH;
    end
    if (rrp) rp = 0;
    else if (r) rp = (rp + 1) % DEPTH;

    write = w; read = r; reset_write_ptr = rwp; reset_read_ptr = rrp; in = d;
    tick();
    if (old_known) check("out_old", out, old_word);
    check("fw_pulse", frame_written, exp_fw);
    write = 1'b0; read = 1'b0; reset_write_ptr = 1'b0; reset_read_ptr = 1'b0;
    tick();
    if (known_m[rp]) check("out_new", out, mem_m[rp]);
    check("fw_clear", frame_written, 0);
    check("overflow", overflow, ovf_m);
    tick();
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      mem_m[i] = '0;
      known_m[i] = 1'b0;
    end
    do_reset();

    // Three writes, rewind, three reads.
    op(1, 0, 0, 0, 4'h1);
    op(1, 0, 0, 0, 4'h2);
    op(1, 0, 0, 0, 4'h3);
    op(0, 0, 0, 1, 4'h0);
    check("first_word", out, 4'h1);
    for (int i = 0; i < 3; i++) op(0, 1, 0, 0, 4'h0);

    // Write held high five cycles stores exactly one word at address 0.
    op(0, 0, 1, 1, 4'h0);
    write = 1'b1; in = 4'hA;
    repeat (5) tick();
    write = 1'b0;
    repeat (2) tick();
    mem_m[0] = 4'hA; known_m[0] = 1'b1; wp = 1;
    check("hold_out", out, 4'hA);
    op(1, 0, 0, 0, 4'h7);
    op(0, 1, 0, 0, 4'h0);
    check("hold_next", out, 4'h7);

    // Full frame, frame_written, overflow on 9th write, overflow sticky across rewind.
    op(0, 0, 1, 1, 4'h0);
    for (int i = 0; i < DEPTH; i++) op(1, 0, 0, 0, 4'(i + 3));
    op(1, 0, 0, 0, 4'hE);
    check("ovf_set", overflow, 1);
    check("mem0_over", out, 4'hE);
    op(0, 0, 1, 0, 4'h0);
    op(1, 0, 0, 0, 4'h9);
    check("ovf_sticky", overflow, 1);

    // Write edge coincident with reset_write_ptr is dropped; next write lands at 0.
    do_reset();
    op(1, 0, 0, 0, 4'h4);
    op(1, 0, 1, 0, 4'hB);
    op(1, 0, 0, 0, 4'h6);
    check("rwp_drop", out, 4'h6);

    // Read-first at a shared address.
    op(0, 0, 1, 1, 4'h0);
    op(1, 0, 0, 0, 4'h1);
    op(1, 0, 0, 0, 4'h2);
    op(1, 0, 0, 0, 4'h5);
    op(0, 1, 0, 0, 4'h0);
    op(0, 1, 0, 0, 4'h0);
    op(0, 0, 1, 0, 4'h0);
    op(1, 0, 0, 0, 4'h1);
    op(1, 0, 0, 0, 4'h2);
    op(1, 0, 0, 0, 4'hC);

    // Reset with write held high across deassertion: no write until a fresh edge.
    write = 1'b1; in = 4'hF;
    do_reset();
    repeat (2) tick();
    write = 1'b0;
    repeat (2) tick();
    check("held_no_wr", out, mem_m[0]);
    op(1, 0, 0, 0, 4'h6);

    // Randomised traffic.
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 59) == 0) do_reset();
      op($urandom_range(0, 2) != 0, $urandom_range(0, 2) == 0,
         $urandom_range(0, 11) == 0, $urandom_range(0, 7) == 0, 4'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
